mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage directly downstream of the EX stage.
- Consumes the EX results (ALUResult as address, MemData as store data, MemReadType, MemRead/MemWrite, RegWrite/MemtoReg, WriteRegister, exception) and drives the data-SRAM request/response handshake.
- Raises a stall to freeze the front end until the access completes.
- Performs store lane replication, load extraction and extension, and address-alignment exception detection, then produces write-back data.

Parameters:
- ADEL_CODE, 4'h4, exception code for a misaligned load
- ADES_CODE, 4'h5, exception code for a misaligned store

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- valid_i  in  1  EX result valid this cycle
- flush  in  1  discard current instruction (exception commit)
- MemRead_i  in  1  load
- MemWrite_i  in  1  store
- MemReadType_i  in  3  [1:0] size: 00 byte, 01 half, 10 word; [2]=1 zero-extend, 0 sign-extend
- ALUResult  in  32  effective address / ALU result
- MemData  in  32  store data (forwarded B)
- RegWrite_i  in  1  write-back enable
- MemtoReg_i  in  1  select load data for write-back
- WriteRegister_i  in  7  destination register
- exception_i  in  4  exception from earlier stages, 0 = none
- data_req  out  1  SRAM request
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  request address
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response / write complete
- data_rdata  in  32  read data
- stall_o  out  1  freeze upstream stages
- valid_o  out  1  result valid for WB
- RegWrite_o  out  1  gated write-back enable
- WriteRegister_o  out  7  destination register
- WBData  out  32  write-back data
- exception_o  out  4  exception code
- BadVAddr  out  32  faulting address

Behaviour:
- Upstream holds every input stable while stall_o=1.
- Alignment error (misaligned):
  - size word: ALUResult[1:0]!=0.
  - size half: ALUResult[0]!=0.
- mem_op = valid_i & (MemRead_i|MemWrite_i) & exception_i==0 & !misaligned & !flush.
- FSM states: IDLE, REQ, WAIT, DONE. Reset (rst=0, async) forces IDLE, cancel=0, rdata_q=0.
- IDLE:
  - If mem_op: stall_o=1, next REQ.
  - Otherwise single-cycle pass-through: valid_o=valid_i&!flush; stall_o=0.
- REQ:
  - data_req=1; stall_o=1.
  - data_addr={ALUResult[31:2],2'b00} for word, else ALUResult.
  - addr_ok=1 -> WAIT. flush with addr_ok=0 -> IDLE, no request issued.
- WAIT:
  - data_req=0; stall_o=1.
  - On data_ok: rdata_q<=data_rdata; next DONE.
  - flush in WAIT sets cancel=1. The outstanding response is still consumed.
- DONE:
  - stall_o=0; valid_o=!cancel.
  - Clear cancel; next IDLE.
- data_req=0 in all states except REQ. data_wr=MemWrite_i; data_size=MemReadType_i[1:0].
- data_wdata:
  - byte {4{MemData[7:0]}}
  - half {2{MemData[15:0]}}
  - word MemData
- Load extract:
  - byte: rdata_q[8*addr[1:0]+:8].
  - half: rdata_q[16*addr[1]+:16].
  - Then sign- or zero-extend per [2].
- WBData = MemtoReg_i ? loaddata : ALUResult.
- WriteRegister_o = WriteRegister_i.
- RegWrite_o = RegWrite_i & valid_o & exception_o==0.
- exception_o / BadVAddr priority:
  - exception_i!=0: exception_i, BadVAddr=0.
  - Else misaligned load: ADEL_CODE, BadVAddr=ALUResult.
  - Else misaligned store: ADES_CODE, BadVAddr=ALUResult.
  - Else 0.
- Misaligned or excepted accesses never assert data_req.
- Response arriving in the same cycle as addr_ok (data_ok in REQ) is not allowed by the SRAM protocol. It is ignored.
- Minimum access latency: 4 cycles (IDLE, REQ, WAIT, DONE). Back-to-back memory ops re-enter REQ one cycle after DONE.

Test Plan:
- Load word: addr 0x100, addr_ok in REQ, data_ok 2 cycles later with 0xDEADBEEF -> data_req high exactly 1 cycle; stall_o high until DONE; DONE cycle WBData=0xDEADBEEF, RegWrite_o=1.
- Load byte signed: addr 0x103, rdata 0x80xxxxxx -> WBData=0xFFFFFF80. Same with MemReadType_i[2]=1 -> WBData=0x00000080.
- Store half: addr 0x202, MemData 0x1234ABCD -> data_wr=1, data_size=1, data_wdata=0xABCDABCD; DONE has RegWrite_o=0.
- Misaligned load word: addr 0x101 -> no data_req; exception_o=4'h4, BadVAddr=0x101, stall_o=0. Same with exception_i=4'h8 -> exception_o=4'h8.
- Flush in WAIT, data_ok arrives 3 cycles later -> DONE has valid_o=0, RegWrite_o=0, FSM back to IDLE; flush in REQ before addr_ok -> IDLE immediately.
- rst low mid-WAIT -> data_req=0, stall_o=0 immediately (async); after release, FSM in IDLE.

Source files
------------

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   MEM pipeline stage between EX and WB. Turns an EX-stage load/store into a
//   request/response transaction on the data SRAM port. While that transaction
//   is in flight it stalls the front end. It replicates store data across the
//   byte lanes, extracts and extends load data, detects misaligned addresses
//   and produces the write-back value.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   valid_i, flush            EX result valid / discard current instruction
//   MemRead_i, MemWrite_i     access kind
//   MemReadType_i[2:0]        [1:0] size (0 byte, 1 half, 2 word), [2] zero-extend
//   ALUResult, MemData        address (or ALU result) and store data
//   RegWrite_i, MemtoReg_i    write-back controls
//   WriteRegister_i           destination register
//   exception_i               exception from earlier stages (0 = none)
//   data_req/wr/size/addr/wdata  SRAM request channel
//   data_addr_ok, data_data_ok, data_rdata  SRAM handshake / response
//   stall_o                   freeze upstream stages
//   valid_o, RegWrite_o, WriteRegister_o, WBData  write-back result
//   exception_o, BadVAddr     exception code and faulting address
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter logic [3:0] ADEL_CODE = 4'h4,
    parameter logic [3:0] ADES_CODE = 4'h5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        flush,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  MemReadType_i,
    input  logic [31:0] ALUResult,
    input  logic [31:0] MemData,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic [6:0]  WriteRegister_i,
    input  logic [3:0]  exception_i,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        stall_o,
    output logic        valid_o,
    output logic        RegWrite_o,
    output logic [6:0]  WriteRegister_o,
    output logic [31:0] WBData,
    output logic [3:0]  exception_o,
    output logic [31:0] BadVAddr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_cancel;
    logic        w_cancel_next;
    logic [31:0] r_rdata_q;

    logic        w_is_word;
    logic        w_is_half;
    logic        w_is_mem;
    logic        w_misaligned;
    logic        w_mem_op;
    logic [31:0] w_byte_shift;
    logic [31:0] w_half_shift;
    logic [31:0] w_load_data;

    assign w_is_word    = (MemReadType_i[1:0] == 2'b10);
    assign w_is_half    = (MemReadType_i[1:0] == 2'b01);
    assign w_is_mem     = MemRead_i | MemWrite_i;
    assign w_misaligned = w_is_mem & ((w_is_word & (ALUResult[1:0] != 2'b00)) |
                                      (w_is_half & ALUResult[0]));
    assign w_mem_op     = valid_i & w_is_mem & (exception_i == 4'h0) &
                          ~w_misaligned & ~flush;

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cancel  <= 1'b0;
            r_rdata_q <= 32'h0;
        end else begin
            r_state  <= w_state_next;
            r_cancel <= w_cancel_next;
            if (r_state == S_WAIT && data_data_ok) begin
                r_rdata_q <= data_rdata;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cancel_next = r_cancel;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                // A flush that coincides with acceptance cannot retract the
                // request, so the response is drained and the result dropped.
                if (data_addr_ok) begin
                    w_state_next = S_WAIT;
                    if (flush) begin
                        w_cancel_next = 1'b1;
                    end
                end else if (flush) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    w_cancel_next = 1'b1;
                end
                if (data_data_ok) begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_cancel_next = 1'b0;
                w_state_next  = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request channel
    // ------------------------------------------------------------------
    assign data_req  = (r_state == S_REQ);
    assign data_wr   = MemWrite_i;
    assign data_size = MemReadType_i[1:0];
    assign data_addr = w_is_word ? {ALUResult[31:2], 2'b00} : ALUResult;

    // Each byte lane carries the store byte the SRAM expects on it for any
    // address offset of the chosen size.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wlane
            always_comb begin
                if (w_is_word) begin
                    data_wdata[8*gi +: 8] = MemData[8*gi +: 8];
                end else if (w_is_half) begin
                    data_wdata[8*gi +: 8] = MemData[8*(gi % 2) +: 8];
                end else begin
                    data_wdata[8*gi +: 8] = MemData[7:0];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake to the pipeline; forced quiet while reset is asserted so
    // upstream is released even if its inputs still describe a memory op.
    // ------------------------------------------------------------------
    always_comb begin
        stall_o = 1'b0;
        valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall_o = w_mem_op;
                valid_o = valid_i & ~flush & ~w_mem_op;
            end
            S_REQ, S_WAIT: begin
                stall_o = 1'b1;
            end
            default: begin
                valid_o = ~r_cancel;
            end
        endcase
        if (!rst) begin
            stall_o = 1'b0;
            valid_o = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Load extraction and write-back
    // ------------------------------------------------------------------
    assign w_byte_shift = r_rdata_q >> {ALUResult[1:0], 3'b000};
    assign w_half_shift = r_rdata_q >> {ALUResult[1], 4'b0000};

    always_comb begin
        if (w_is_half) begin
            w_load_data = {{16{~MemReadType_i[2] & w_half_shift[15]}}, w_half_shift[15:0]};
        end else if (MemReadType_i[1:0] == 2'b00) begin
            w_load_data = {{24{~MemReadType_i[2] & w_byte_shift[7]}}, w_byte_shift[7:0]};
        end else begin
            w_load_data = r_rdata_q;
        end
    end

    assign WBData          = MemtoReg_i ? w_load_data : ALUResult;
    assign WriteRegister_o = WriteRegister_i;
    assign RegWrite_o      = RegWrite_i & valid_o & (exception_o == 4'h0);

    always_comb begin
        exception_o = 4'h0;
        BadVAddr    = 32'h0;
        if (exception_i != 4'h0) begin
            exception_o = exception_i;
        end else if (w_misaligned & MemRead_i) begin
            exception_o = ADEL_CODE;
            BadVAddr    = ALUResult;
        end else if (w_misaligned & MemWrite_i) begin
            exception_o = ADES_CODE;
            BadVAddr    = ALUResult;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        flush = 1'b0;
    logic        MemRead_i = 1'b0;
    logic        MemWrite_i = 1'b0;
    logic [2:0]  MemReadType_i = 3'b010;
    logic [31:0] ALUResult = 32'h0;
    logic [31:0] MemData = 32'h0;
    logic        RegWrite_i = 1'b0;
    logic        MemtoReg_i = 1'b0;
    logic [6:0]  WriteRegister_i = 7'h0;
    logic [3:0]  exception_i = 4'h0;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'h0;
    logic        stall_o;
    logic        valid_o;
    logic        RegWrite_o;
    logic [6:0]  WriteRegister_o;
    logic [31:0] WBData;
    logic [3:0]  exception_o;
    logic [31:0] BadVAddr;

    int n_pass  = 0;
    int n_total = 0;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush(flush),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .MemReadType_i(MemReadType_i),
        .ALUResult(ALUResult), .MemData(MemData), .RegWrite_i(RegWrite_i),
        .MemtoReg_i(MemtoReg_i), .WriteRegister_i(WriteRegister_i), .exception_i(exception_i),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .stall_o(stall_o), .valid_o(valid_o), .RegWrite_o(RegWrite_o),
        .WriteRegister_o(WriteRegister_o), .WBData(WBData), .exception_o(exception_o),
        .BadVAddr(BadVAddr)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_wdata(input logic [2:0] typ, input logic [31:0] d);
        if (typ[1:0] == 2'd0) return {24'h0, d[7:0]} * 32'h01010101;
        if (typ[1:0] == 2'd1) return {16'h0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] typ, input logic [31:0] a,
                                           input logic [31:0] r);
        int nbits;
        int off;
        logic [31:0] mask;
        logic [31:0] v;
        if (typ[1:0] == 2'd2) return r;
        nbits = (typ[1:0] == 2'd0) ? 8 : 16;
        off   = (typ[1:0] == 2'd0) ? int'(a[1:0]) : 2 * int'(a[1]);
        mask  = (32'h1 << nbits) - 32'h1;
        v     = (r >> (8 * off)) & mask;
        if (!typ[2] && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] m_addr(input logic [2:0] typ, input logic [31:0] a);
        return (typ[1:0] == 2'd2) ? (a & 32'hFFFF_FFFC) : a;
    endfunction

    task automatic set_idle_inputs();
        valid_i = 1'b0; flush = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        RegWrite_i = 1'b0; MemtoReg_i = 1'b0; exception_i = 4'h0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
    endtask

    // One full memory access; flush_at selects a WAIT cycle index for a flush pulse (-1 = none).
    task automatic mem_access(input string tag, input bit rd, input logic [2:0] typ,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdat, input int ao_wait,
                              input int dk_wait, input int flush_at);
        logic [31:0] exp_wb;
        bit          cancel;
        logic [6:0]  dst;
        exp_wb = rd ? m_load(typ, addr, rdat) : addr;
        cancel = (flush_at >= 0);
        dst    = 7'($urandom_range(1, 127));
        @(negedge clk);
        valid_i = 1'b1; MemRead_i = rd; MemWrite_i = !rd; MemReadType_i = typ;
        ALUResult = addr; MemData = wd; RegWrite_i = rd; MemtoReg_i = rd;
        WriteRegister_i = dst; exception_i = 4'h0; flush = 1'b0;
        #1;
        n_total++;
        if (stall_o !== 1'b1 || data_req !== 1'b0 || valid_o !== 1'b0)
            $display("FAIL %s idle: stall=%b req=%b valid=%b exp stall=1 req=0 valid=0",
                     tag, stall_o, data_req, valid_o);
        else n_pass++;
        for (int i = 0; i <= ao_wait; i++) begin
            @(negedge clk);
            data_addr_ok = (i == ao_wait);
            #1;
            n_total++;
            if (data_req !== 1'b1 || stall_o !== 1'b1 || data_wr !== !rd ||
                data_size !== typ[1:0] || data_addr !== m_addr(typ, addr) ||
                (!rd && data_wdata !== m_wdata(typ, wd)))
                $display("FAIL %s req: req=%b stall=%b wr=%b size=%0d addr=%h wdata=%h exp req=1 stall=1 wr=%b size=%0d addr=%h wdata=%h",
                         tag, data_req, stall_o, data_wr, data_size, data_addr, data_wdata,
                         !rd, typ[1:0], m_addr(typ, addr), m_wdata(typ, wd));
            else n_pass++;
        end
        for (int j = 0; j <= dk_wait; j++) begin
            @(negedge clk);
            data_addr_ok = 1'b0;
            data_data_ok = (j == dk_wait);
            data_rdata   = (j == dk_wait) ? rdat : $urandom;
            flush        = (j == flush_at);
            #1;
            n_total++;
            if (data_req !== 1'b0 || stall_o !== 1'b1 || valid_o !== 1'b0)
                $display("FAIL %s wait: req=%b stall=%b valid=%b exp req=0 stall=1 valid=0",
                         tag, data_req, stall_o, valid_o);
            else n_pass++;
        end
        @(negedge clk);
        data_data_ok = 1'b0; flush = 1'b0; data_rdata = $urandom;
        #1;
        n_total++;
        if (stall_o !== 1'b0 || data_req !== 1'b0 || valid_o !== !cancel ||
            RegWrite_o !== (rd && !cancel) || WriteRegister_o !== dst ||
            (!cancel && WBData !== exp_wb))
            $display("FAIL %s done: stall=%b req=%b valid=%b regw=%b wr=%0d wb=%h exp stall=0 req=0 valid=%b regw=%b wr=%0d wb=%h",
                     tag, stall_o, data_req, valid_o, RegWrite_o, WriteRegister_o, WBData,
                     !cancel, rd && !cancel, dst, exp_wb);
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_idle_inputs();
        MemReadType_i = 3'b010; MemtoReg_i = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if (data_req !== 1'b0 || stall_o !== 1'b0 || valid_o !== 1'b0 || WBData !== 32'h0 ||
            exception_o !== 4'h0)
            $display("FAIL reset: req=%b stall=%b valid=%b wb=%h exc=%h exp 0 0 0 00000000 0",
                     data_req, stall_o, valid_o, WBData, exception_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1; MemtoReg_i = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [31:0] v;
        for (int k = 0; k < 4; k++) begin
            v = $urandom;
            @(negedge clk);
            set_idle_inputs();
            valid_i = 1'b1; RegWrite_i = 1'b1; ALUResult = v; flush = (k == 3);
            WriteRegister_i = 7'(k + 5);
            #1;
            n_total++;
            if (stall_o !== 1'b0 || data_req !== 1'b0 || valid_o !== (k != 3) ||
                RegWrite_o !== (k != 3) || WBData !== v || WriteRegister_o !== 7'(k + 5))
                $display("FAIL passthru%0d: stall=%b req=%b valid=%b regw=%b wb=%h wr=%0d exp valid=%b wb=%h",
                         k, stall_o, data_req, valid_o, RegWrite_o, WBData, WriteRegister_o,
                         k != 3, v);
            else n_pass++;
        end
        @(negedge clk);
        set_idle_inputs();
    endtask

    task automatic test_directed();
        mem_access("lw", 1'b1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, -1);
        mem_access("lb_s", 1'b1, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 0, -1);
        mem_access("lbu", 1'b1, 3'b100, 32'h103, 32'h0, 32'h80123456, 1, 0, -1);
        mem_access("sh", 1'b0, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, 0, -1);
        mem_access("lh_s", 1'b1, 3'b001, 32'h302, 32'h0, 32'hF00D1234, 2, 2, -1);
    endtask

    task automatic test_misaligned();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_idle_inputs();
            valid_i = 1'b1; MemRead_i = (k != 1); MemWrite_i = (k == 1);
            MemReadType_i = (k == 1) ? 3'b001 : 3'b010; ALUResult = 32'h101;
            RegWrite_i = 1'b1; MemtoReg_i = 1'b1; exception_i = (k == 2) ? 4'h8 : 4'h0;
            #1;
            n_total++;
            if (data_req !== 1'b0 || stall_o !== 1'b0 || RegWrite_o !== 1'b0 ||
                exception_o !== ((k == 2) ? 4'h8 : (k == 1) ? 4'h5 : 4'h4) ||
                BadVAddr !== ((k == 2) ? 32'h0 : 32'h101))
                $display("FAIL misalign%0d: req=%b stall=%b regw=%b exc=%h bad=%h",
                         k, data_req, stall_o, RegWrite_o, exception_o, BadVAddr);
            else n_pass++;
            @(negedge clk);
            #1;
            n_total++;
            if (data_req !== 1'b0 || stall_o !== 1'b0)
                $display("FAIL misalign%0d_hold: req=%b stall=%b exp 0 0", k, data_req, stall_o);
            else n_pass++;
        end
        @(negedge clk);
        set_idle_inputs();
    endtask

    task automatic test_flush();
        mem_access("flush_wait", 1'b1, 3'b010, 32'h400, 32'h0, 32'h11223344, 0, 3, 0);
        @(negedge clk);
        set_idle_inputs();
        valid_i = 1'b1; MemRead_i = 1'b1; MemReadType_i = 3'b010; ALUResult = 32'h500;
        #1;
        @(negedge clk);
        flush = 1'b1;
        #1;
        n_total++;
        if (data_req !== 1'b1)
            $display("FAIL flush_req_pre: req=%b exp 1", data_req);
        else n_pass++;
        @(negedge clk);
        set_idle_inputs();
        #1;
        n_total++;
        if (data_req !== 1'b0 || stall_o !== 1'b0 || valid_o !== 1'b0)
            $display("FAIL flush_req_idle: req=%b stall=%b valid=%b exp 0 0 0",
                     data_req, stall_o, valid_o);
        else n_pass++;
        mem_access("after_flush", 1'b1, 3'b010, 32'h504, 32'h0, 32'hCAFEF00D, 0, 0, -1);
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        set_idle_inputs();
        valid_i = 1'b1; MemRead_i = 1'b1; MemReadType_i = 3'b010; ALUResult = 32'h600;
        @(negedge clk);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_total++;
        if (data_req !== 1'b0 || stall_o !== 1'b0)
            $display("FAIL rst_wait_async: req=%b stall=%b exp 0 0", data_req, stall_o);
        else n_pass++;
        set_idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        data_data_ok = 1'b1;
        #1;
        n_total++;
        if (data_req !== 1'b0 || stall_o !== 1'b0 || valid_o !== 1'b0)
            $display("FAIL rst_wait_idle: req=%b stall=%b valid=%b exp 0 0 0",
                     data_req, stall_o, valid_o);
        else n_pass++;
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        n_total++;
        if (valid_o !== 1'b0)
            $display("FAIL rst_wait_nodone: valid=%b exp 0", valid_o);
        else n_pass++;
        mem_access("after_rst", 1'b0, 3'b000, 32'h701, 32'h000000A5, 32'h0, 0, 0, -1);
    endtask

    task automatic test_back_to_back();
        bit          rd;
        logic [2:0]  typ;
        logic [31:0] a;
        for (int k = 0; k < 16; k++) begin
            rd  = 1'($urandom_range(0, 1));
            typ = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
            a   = $urandom;
            if (typ[1:0] == 2'd2) a[1:0] = 2'b00;
            if (typ[1:0] == 2'd1) a[0] = 1'b0;
            mem_access($sformatf("rand%0d", k), rd, typ, a, $urandom, $urandom,
                       $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end
        @(negedge clk);
        set_idle_inputs();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_directed();
        test_misaligned();
        test_flush();
        test_reset_in_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
